layer_compositor: RTL
=====================

Name: layer_compositor

Overview:
- Parametrised successor to the GPU pixel-priority mux.
- Merges LAYERS cluster pixel streams into one registered RGB output, with a configurable transparency key, background colour and per-layer enable mask.
- Configuration is held in shadow registers and committed atomically at vsync falling edge, so there is no mid-frame tearing.
- Also keeps a frame counter and raises a vblank interrupt. Sits between the clusters/vga_counter and the VGA pins; registers are driven from the axil_controller write port plus a simple read port.

Parameters:
LAYERS, 5, number of layer pixel inputs; index 0 = highest priority
COLOR_WIDTH, 12, bits per pixel (RGB444 split equally in thirds)
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 8, register word-index width
BG_RESET, 12'h8CE, reset background colour
KEY_RESET, 12'hFFF, reset transparency key

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
waddr  in  ADDR_WIDTH  register word index for writes
wdata  in  DATA_WIDTH  write data
wen  in  1  write strobe, one cycle per write
raddr  in  ADDR_WIDTH  register word index for reads
ren  in  1  read strobe
rdata  out  DATA_WIDTH  read data
rvalid  out  1  rdata valid
layer_pixel  in  LAYERS*COLOR_WIDTH  flat bus; layer k at [k*COLOR_WIDTH +: COLOR_WIDTH]
visible  in  1  active video
vsync  in  1  vga vsync (active-low pulse)
red/green/blue  out  COLOR_WIDTH/3 each  VGA colour
irq  out  1  vblank interrupt
frame_count  out  DATA_WIDTH  frames completed

Behaviour:
- Register map (word index; other indices: writes ignored, reads return 0):
  - 0 CTRL: bit0 ENABLE (reset 1). bit1 COMMIT (write 1 sets commit_pending; reads return commit_pending).
  - 1 BG_COLOR, shadow, reset BG_RESET.
  - 2 KEY_COLOR, shadow, reset KEY_RESET.
  - 3 LAYER_EN [LAYERS-1:0], shadow, reset all ones.
  - 4 STATUS: bit0 VBLANK pending, W1C.
  - 5 FRAME_COUNT, read-only.
  - 6 IRQ_EN: bit0, reset 0.
- Registers 1-3 read back their shadow values. Active copies reset to the same values as the shadows.
- Edge detect: last_vsync resets to 1. vsync_fall = last_vsync & ~vsync.
- On vsync_fall:
  - frame_count increments, wrapping at 2^DATA_WIDTH.
  - STATUS.VBLANK is set.
  - If commit_pending, the active registers load the shadows and commit_pending clears.
- Simultaneous events on the same cycle as vsync_fall:
  - A shadow write: active loads the pre-write shadow value; the new value stays in the shadow.
  - A COMMIT write: not applied at this edge; commit_pending is 1 afterwards.
  - A STATUS W1C: set wins; VBLANK stays 1.
- irq = VBLANK & IRQ_EN, registered. It drops the cycle after a W1C clears VBLANK.
- Compositing: pixel output is registered, 1 clk latency from layer_pixel/visible.
  - If visible is 0: output 0.
  - Else if ENABLE is 0: active BG.
  - Else: the lowest k with active LAYER_EN[k] = 1 and layer_pixel[k] != active KEY; if no such k, active BG.
- ENABLE is not shadowed; it takes effect immediately.
- Read: ren in cycle N gives rdata/rvalid in cycle N+1. rvalid is high for exactly one cycle; rdata holds its value otherwise.
- Write and read in the same cycle to the same register: read returns the old value.
- Reset state: all RGB 0, irq 0, rvalid 0, rdata 0, frame_count 0, commit_pending 0, VBLANK 0.
- Reset asserted mid-frame aborts a pending commit.

Decomposition:
- gpu_pkg holds:
  - register index constants (REG_CTRL..REG_IRQ_EN);
  - CTRL/STATUS bit positions;
  - a typedef for the active configuration struct (bg, key, layer_en).
- One sub-module, compositor_regs: register file, shadow/active commit and read port.
- The layer_compositor top keeps the edge detect, counter and priority mux.

Test Plan:
- After reset, visible=1, all layers 12'hFFF -> RGB = 8/C/E one cycle later; frame_count 0, irq 0.
- Layers 0..4 = FFF, 123, 456, FFF, FFF -> output 123. Then write LAYER_EN=5'b11101 + COMMIT, pulse vsync -> output 456 and frame_count 1.
- Write BG_COLOR=0F0 without COMMIT, pulse vsync -> BG still 8CE and read of reg 1 = 0F0. Write COMMIT, pulse vsync -> BG 0F0.
- IRQ_EN=1, pulse vsync -> irq=1 and STATUS=1. W1C write of 1 to STATUS on the same cycle as the next vsync falling edge -> STATUS stays 1. Separate W1C -> irq 0 next cycle.
- COMMIT written on the exact vsync_fall cycle -> CTRL read bit1 = 1 afterwards; the shadow is applied on the following vsync.
- Force frame_count to all-ones (via 2^32 pulses or a bench force), pulse vsync -> 0. Read of index 7 -> 0; visible=0 -> RGB 0.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// gpu_pkg: shared constants and types for the layer compositor slice.
//   - register word indices (REG_CTRL .. REG_IRQ_EN)
//   - CTRL / STATUS bit positions
//   - cfg_t: the configuration that is double-buffered (shadow/active)
// cfg_t is sized by LAYERS_P / COLOR_WIDTH_P; the module parameters
// LAYERS / COLOR_WIDTH default to these and must be kept equal to them.
package gpu_pkg;

  localparam int LAYERS_P      = 5;
  localparam int COLOR_WIDTH_P = 12;

  localparam int REG_CTRL        = 0;
  localparam int REG_BG_COLOR    = 1;
  localparam int REG_KEY_COLOR   = 2;
  localparam int REG_LAYER_EN    = 3;
  localparam int REG_STATUS      = 4;
  localparam int REG_FRAME_COUNT = 5;
  localparam int REG_IRQ_EN      = 6;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_COMMIT_BIT   = 1;
  localparam int STATUS_VBLANK_BIT = 0;

  typedef struct packed {
    logic [COLOR_WIDTH_P-1:0] bg;
    logic [COLOR_WIDTH_P-1:0] key;
    logic [LAYERS_P-1:0]      layer_en;
  } cfg_t;

endpackage

// File: rtl/layer_compositor_if.sv
// Register access bus between the AXI-lite controller and the compositor.
// Handshake: wen and ren are single-cycle strobes that are always accepted
// (there is no ready); a read strobed in cycle N returns rdata together with
// a one-cycle rvalid pulse in cycle N+1, and rdata holds between reads.
//   master: drives waddr/wdata/wen/raddr/ren, receives rdata/rvalid
//   slave : the register file side
interface layer_compositor_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output waddr, wdata, wen, raddr, ren,
    input  rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wen, raddr, ren,
    output rdata, rvalid
  );
endinterface

// File: rtl/layer_compositor_regs.sv
// compositor_regs: register file of the layer compositor.
// Holds CTRL (ENABLE, commit_pending), the shadow and active copies of the
// configuration, STATUS.VBLANK, IRQ_EN and the registered read port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus               register bus (slave side)
//   vsync_fall_i      one-cycle pulse at the vsync falling edge
//   frame_count_i     frame counter value for FRAME_COUNT reads
//   active_o          active configuration used by the pixel mux
//   enable_o          CTRL.ENABLE (not double-buffered)
//   commit_pending_o  commit waiting for the next vsync falling edge
//   irq_o             registered vblank interrupt
module compositor_regs
  import gpu_pkg::*;
#(
  parameter int                     LAYERS      = LAYERS_P,
  parameter int                     COLOR_WIDTH = COLOR_WIDTH_P,
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     ADDR_WIDTH  = 8,
  parameter logic [COLOR_WIDTH-1:0] BG_RESET    = 12'h8CE,
  parameter logic [COLOR_WIDTH-1:0] KEY_RESET   = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_compositor_if.slave     bus,
  input  logic                  vsync_fall_i,
  input  logic [DATA_WIDTH-1:0] frame_count_i,
  output cfg_t                  active_o,
  output logic                  enable_o,
  output logic                  commit_pending_o,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(REG_CTRL);
  localparam logic [ADDR_WIDTH-1:0] A_BG     = ADDR_WIDTH'(REG_BG_COLOR);
  localparam logic [ADDR_WIDTH-1:0] A_KEY    = ADDR_WIDTH'(REG_KEY_COLOR);
  localparam logic [ADDR_WIDTH-1:0] A_LEN    = ADDR_WIDTH'(REG_LAYER_EN);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(REG_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_FCNT   = ADDR_WIDTH'(REG_FRAME_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'(REG_IRQ_EN);

  localparam cfg_t CFG_RESET = '{bg: BG_RESET, key: KEY_RESET, layer_en: '1};

  logic            enable_q, enable_d;
  logic            commit_q, commit_d;
  logic            vblank_q, vblank_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  cfg_t            shadow_q, shadow_d;
  cfg_t            active_q, active_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic            rvalid_q;

  logic wr_ctrl, wr_bg, wr_key, wr_len, wr_status, wr_irqen;

  assign wr_ctrl   = bus.wen && (bus.waddr == A_CTRL);
  assign wr_bg     = bus.wen && (bus.waddr == A_BG);
  assign wr_key    = bus.wen && (bus.waddr == A_KEY);
  assign wr_len    = bus.wen && (bus.waddr == A_LEN);
  assign wr_status = bus.wen && (bus.waddr == A_STATUS);
  assign wr_irqen  = bus.wen && (bus.waddr == A_IRQEN);

  always_comb begin
    enable_d = enable_q;
    commit_d = commit_q;
    vblank_d = vblank_q;
    irq_en_d = irq_en_q;
    shadow_d = shadow_q;
    active_d = active_q;

    if (wr_ctrl) enable_d = bus.wdata[CTRL_ENABLE_BIT];
    if (wr_bg)   shadow_d.bg       = bus.wdata[COLOR_WIDTH-1:0];
    if (wr_key)  shadow_d.key      = bus.wdata[COLOR_WIDTH-1:0];
    if (wr_len)  shadow_d.layer_en = bus.wdata[LAYERS-1:0];
    if (wr_irqen) irq_en_d = bus.wdata[0];

    // Commit uses the registered shadow, so a shadow write landing on the
    // same edge is held back for the next commit.
    if (vsync_fall_i && commit_q) active_d = shadow_q;
    if (vsync_fall_i) commit_d = 1'b0;
    // A COMMIT write on the edge itself re-arms for the next frame.
    if (wr_ctrl && bus.wdata[CTRL_COMMIT_BIT]) commit_d = 1'b1;

    // W1C first, then set: a new vblank beats a concurrent clear.
    if (wr_status && bus.wdata[STATUS_VBLANK_BIT]) vblank_d = 1'b0;
    if (vsync_fall_i) vblank_d = 1'b1;

    irq_d = vblank_d & irq_en_d;
  end

  // Read mux sees only registered values, so a same-cycle write reads old.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.ren) begin
      rdata_d = '0;
      case (bus.raddr)
        A_CTRL:   rdata_d = DATA_WIDTH'({commit_q, enable_q});
        A_BG:     rdata_d = DATA_WIDTH'(shadow_q.bg);
        A_KEY:    rdata_d = DATA_WIDTH'(shadow_q.key);
        A_LEN:    rdata_d = DATA_WIDTH'(shadow_q.layer_en);
        A_STATUS: rdata_d = DATA_WIDTH'(vblank_q);
        A_FCNT:   rdata_d = frame_count_i;
        A_IRQEN:  rdata_d = DATA_WIDTH'(irq_en_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b1;
      commit_q <= 1'b0;
      vblank_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      shadow_q <= CFG_RESET;
      active_q <= CFG_RESET;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      enable_q <= enable_d;
      commit_q <= commit_d;
      vblank_q <= vblank_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.ren;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign active_o         = active_q;
  assign enable_o         = enable_q;
  assign commit_pending_o = commit_q;
  assign irq_o            = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[DATA_WIDTH-1:COLOR_WIDTH];

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: merges LAYERS pixel streams into one registered RGB
// output. Layer 0 has the highest priority; a layer pixel equal to the
// active key colour is transparent; background fills the rest.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             register bus (slave side)
//   layer_pixel_i   flat bus, layer k at [k*COLOR_WIDTH +: COLOR_WIDTH]
//   visible_i       active video
//   vsync_i         VGA vsync, active-low pulse
//   red_o/green_o/blue_o  registered colour, 1 clk after layer_pixel_i
//   irq_o           vblank interrupt
//   frame_count_o   frames completed (vsync falling edges)
//   commit_pending_o  debug view of the pending commit
module layer_compositor
  import gpu_pkg::*;
#(
  parameter int                     LAYERS      = LAYERS_P,
  parameter int                     COLOR_WIDTH = COLOR_WIDTH_P,
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     ADDR_WIDTH  = 8,
  parameter logic [COLOR_WIDTH-1:0] BG_RESET    = 12'h8CE,
  parameter logic [COLOR_WIDTH-1:0] KEY_RESET   = 12'hFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  layer_compositor_if.slave             bus,
  input  logic [LAYERS*COLOR_WIDTH-1:0] layer_pixel_i,
  input  logic                          visible_i,
  input  logic                          vsync_i,
  output logic [COLOR_WIDTH/3-1:0]      red_o,
  output logic [COLOR_WIDTH/3-1:0]      green_o,
  output logic [COLOR_WIDTH/3-1:0]      blue_o,
  output logic                          irq_o,
  output logic [DATA_WIDTH-1:0]         frame_count_o,
  output logic                          commit_pending_o
);

  localparam int CW3 = COLOR_WIDTH / 3;

  logic                   last_vsync_q;
  logic                   vsync_fall;
  logic [DATA_WIDTH-1:0]  frame_count_q, frame_count_d;
  logic [COLOR_WIDTH-1:0] pix_q, pix_d;
  cfg_t                   active;
  logic                   enable;

  assign vsync_fall    = last_vsync_q & ~vsync_i;
  assign frame_count_d = vsync_fall ? frame_count_q + 1'b1 : frame_count_q;

  compositor_regs #(
    .LAYERS      (LAYERS),
    .COLOR_WIDTH (COLOR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BG_RESET    (BG_RESET),
    .KEY_RESET   (KEY_RESET)
  ) u_regs (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .vsync_fall_i     (vsync_fall),
    .frame_count_i    (frame_count_q),
    .active_o         (active),
    .enable_o         (enable),
    .commit_pending_o (commit_pending_o),
    .irq_o            (irq_o)
  );

  // Scan from lowest priority upward so the lowest opaque enabled index
  // is the last assignment and wins.
  always_comb begin
    pix_d = active.bg;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (active.layer_en[k] &&
          (layer_pixel_i[k*COLOR_WIDTH +: COLOR_WIDTH] != active.key)) begin
        pix_d = layer_pixel_i[k*COLOR_WIDTH +: COLOR_WIDTH];
      end
    end
    if (!enable)    pix_d = active.bg;
    if (!visible_i) pix_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_vsync_q  <= 1'b1;
      frame_count_q <= '0;
      pix_q         <= '0;
    end else begin
      last_vsync_q  <= vsync_i;
      frame_count_q <= frame_count_d;
      pix_q         <= pix_d;
    end
  end

  assign red_o         = pix_q[COLOR_WIDTH-1 -: CW3];
  assign green_o       = pix_q[2*CW3-1 -: CW3];
  assign blue_o        = pix_q[CW3-1:0];
  assign frame_count_o = frame_count_q;

endmodule
